// File: rtl/macarray_sys.sv
`default_nettype none
// ============================================================================
// Module      : macarray_sys
// Description : Output-stationary systolic MAC array, O[MxN] = I[MxT] * W[TxN].
//               Streams column k of I and row k of W from single-port read
//               memories, skews them into a ROWS x COLS PE grid, then writes
//               the M result rows to the output memory.
// Ports       : CLK/RST        clock, async active-high reset
//               MNT/SIGNED     problem size {M,N,T} and signedness, taken with START
//               START          request; BUSY/DONE/ERR status
//               EN_I/ADDR_I/RDATA_I, EN_W/ADDR_W/RDATA_W   operand memory reads
//               EN_O/RW_O/ADDR_O/WDATA_O                  result row writes
// Revision    : 1.0 - initial release
// ============================================================================
module macarray_sys #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int KMAX  = 8,
    parameter int DW    = 8,
    parameter int ACC_W = 20,
    parameter int AW_IW = 3,
    parameter int AW_O  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [11:0]             MNT,
    input  logic                    SIGNED,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR,
    output logic                    EN_I,
    output logic [AW_IW-1:0]        ADDR_I,
    input  logic [ROWS*DW-1:0]      RDATA_I,
    output logic                    EN_W,
    output logic [AW_IW-1:0]        ADDR_W,
    input  logic [COLS*DW-1:0]      RDATA_W,
    output logic                    EN_O,
    output logic                    RW_O,
    output logic [AW_O-1:0]         ADDR_O,
    output logic [COLS*ACC_W-1:0]   WDATA_O
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [3:0] c_rows       = 4'(ROWS);
    localparam logic [3:0] c_cols       = 4'(COLS);
    localparam logic [3:0] c_kmax       = 4'(KMAX);
    // Drain lasts ROWS+COLS-1 cycles so the last product reaches PE(ROWS-1,COLS-1).
    localparam logic [4:0] c_drain_last = 5'(ROWS + COLS - 2);

    logic [2:0] r_state, w_state_nxt;
    logic [4:0] r_cnt;
    logic [3:0] r_m, r_n, r_t;
    logic       r_signed, r_vld, r_err;

    logic [3:0] w_m, w_n, w_t;
    logic       w_legal, w_accept;

    assign w_m      = MNT[11:8];
    assign w_n      = MNT[7:4];
    assign w_t      = MNT[3:0];
    assign w_legal  = (w_m != 4'd0) && (w_m <= c_rows) &&
                      (w_n != 4'd0) && (w_n <= c_cols) &&
                      (w_t != 4'd0) && (w_t <= c_kmax);
    assign w_accept = (r_state == S_IDLE) && START && w_legal;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                          w_state_nxt = S_LOAD;
            S_LOAD:  if (r_cnt == {1'b0, r_t} - 5'd1)       w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_cnt == c_drain_last)             w_state_nxt = S_WRITE;
            S_WRITE: if (r_cnt == {1'b0, r_m} - 5'd1)       w_state_nxt = S_FIN;
            S_FIN:                                          w_state_nxt = S_IDLE;
            default:                                        w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter restarts at every state change; job parameters latched on accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_t      <= '0;
            r_signed <= 1'b0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? 5'd0 : r_cnt + 5'd1;
            // Read data is returned one cycle after the enable.
            r_vld <= (r_state == S_LOAD);
            r_err <= (r_state == S_IDLE) && START && !w_legal;
            if (w_accept) begin
                r_m      <= w_m;
                r_n      <= w_n;
                r_t      <= w_t;
                r_signed <= SIGNED;
            end
        end
    end

    // ---------------- input lanes and skew ----------------
    logic [DW-1:0] w_ilane [ROWS];
    logic [DW-1:0] w_wlane [COLS];
    logic [DW-1:0] w_a_west [ROWS];
    logic [DW-1:0] w_b_north [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_iskew
        // Masked rows and non-returning cycles inject zero bubbles.
        assign w_ilane[r] = (r_vld && (4'(r) < r_m)) ? RDATA_I[r*DW +: DW] : '0;
        if (r == 0) begin : g_direct
            assign w_a_west[r] = w_ilane[r];
        end else begin : g_delay
            logic [DW-1:0] r_sk [r];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_ilane[r];
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_a_west[r] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wskew
        assign w_wlane[c] = (r_vld && (4'(c) < r_n)) ? RDATA_W[c*DW +: DW] : '0;
        if (c == 0) begin : g_direct
            assign w_b_north[c] = w_wlane[c];
        end else begin : g_delay
            logic [DW-1:0] r_sk [c];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < c; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_wlane[c];
                    for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_b_north[c] = r_sk[c-1];
        end
    end

    // ---------------- PE grid ----------------
    // Each PE multiplies the operands presented at its inputs this cycle, then
    // registers them to pass east (a) and south (b) for the next cycle.
    logic [DW-1:0]    w_a_in [ROWS][COLS];
    logic [DW-1:0]    w_b_in [ROWS][COLS];
    logic [DW-1:0]    w_a_q  [ROWS][COLS];
    logic [DW-1:0]    w_b_q  [ROWS][COLS];
    logic [ACC_W-1:0] w_acc  [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [DW-1:0]    r_a, r_b;
            logic [ACC_W-1:0] r_acc, w_ea, w_eb, w_prod;

            if (c == 0) begin : g_a_edge
                assign w_a_in[r][c] = w_a_west[r];
            end else begin : g_a_link
                assign w_a_in[r][c] = w_a_q[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign w_b_in[r][c] = w_b_north[c];
            end else begin : g_b_link
                assign w_b_in[r][c] = w_b_q[r-1][c];
            end

            assign w_ea   = r_signed ? {{(ACC_W-DW){w_a_in[r][c][DW-1]}}, w_a_in[r][c]}
                                     : {{(ACC_W-DW){1'b0}}, w_a_in[r][c]};
            assign w_eb   = r_signed ? {{(ACC_W-DW){w_b_in[r][c][DW-1]}}, w_b_in[r][c]}
                                     : {{(ACC_W-DW){1'b0}}, w_b_in[r][c]};
            // Product truncated to ACC_W: modular arithmetic is exact for both signednesses.
            assign w_prod = w_ea * w_eb;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else begin
                    r_a   <= w_a_in[r][c];
                    r_b   <= w_b_in[r][c];
                    r_acc <= w_accept ? '0 : r_acc + w_prod;
                end
            end

            assign w_a_q[r][c] = r_a;
            assign w_b_q[r][c] = r_b;
            assign w_acc[r][c] = r_acc;
        end
    end

    // Result row selected by the write-phase counter; unused columns forced to zero.
    logic [COLS*ACC_W-1:0] w_row_data;
    for (genvar c = 0; c < COLS; c++) begin : g_wcol
        assign w_row_data[c*ACC_W +: ACC_W] =
            (4'(c) < r_n) ? w_acc[r_cnt[AW_O-1:0]][c] : '0;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY    = (r_state != S_IDLE);
        DONE    = (r_state == S_FIN);
        ERR     = r_err;
        EN_I    = 1'b0;
        ADDR_I  = '0;
        EN_W    = 1'b0;
        ADDR_W  = '0;
        EN_O    = 1'b0;
        RW_O    = 1'b0;
        ADDR_O  = '0;
        WDATA_O = '0;
        case (r_state)
            S_LOAD: begin
                EN_I   = 1'b1;
                EN_W   = 1'b1;
                ADDR_I = r_cnt[AW_IW-1:0];
                ADDR_W = r_cnt[AW_IW-1:0];
            end
            S_WRITE: begin
                EN_O    = 1'b1;
                RW_O    = 1'b1;
                ADDR_O  = r_cnt[AW_O-1:0];
                WDATA_O = w_row_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
